// File: rtl/dma_responder_pkg.sv
// Shared types and constants for the memory-backed DMA responder.
package dma_responder_pkg;

  localparam int CL_OFFSET = 6;
  localparam int LINE_BITS = 512;
  localparam int CNT_BITS  = 43;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [CNT_BITS-1:0]  count_t;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_ACTIVE = 2'd1,
    RD_DONE   = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_ACTIVE = 2'd1,
    WR_DONE   = 2'd2
  } wr_state_t;

endpackage

// File: rtl/dma_resp_fifo.sv
// First-word-fall-through FIFO; head of queue is visible on rdata while empty=0.
module dma_resp_fifo
  import dma_responder_pkg::*;
#(
  parameter int WIDTH = 512,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/dma_responder.sv
// Host-side DMA responder: read/write channels share one single-port line RAM,
// with a backdoor port that always wins the RAM slot.
module dma_responder
  import dma_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int MEM_AW     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [SIZE_WIDTH-1:0] rd_size,
  input  logic                  rd_go,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  rd_done,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] wr_size,
  input  logic                  wr_go,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  wr_done,
  input  logic                  bd_en,
  input  logic                  bd_we,
  input  logic [MEM_AW-1:0]     bd_addr,
  input  logic [DATA_WIDTH-1:0] bd_wdata,
  output logic [DATA_WIDTH-1:0] bd_rdata
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  rd_state_t             rd_state;
  wr_state_t             wr_state;
  logic [MEM_AW-1:0]     rd_line;
  logic [MEM_AW-1:0]     wr_line;
  logic [MEM_AW-1:0]     ram_addr;
  logic [SIZE_WIDTH-1:0] rd_issue;
  logic [SIZE_WIDTH-1:0] rd_left;
  logic [SIZE_WIDTH-1:0] wr_push_left;
  logic [SIZE_WIDTH-1:0] wr_left;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] wf_data;
  logic [FCW-1:0]        rf_count;
  logic [FCW-1:0]        wf_count;
  logic [FCW-1:0]        rd_room;
  logic                  rd_pending;
  logic                  prio;
  logic                  rd_req;
  logic                  wr_req;
  logic                  rd_grant;
  logic                  wr_grant;
  logic                  rd_pop;
  logic                  wr_push;
  logic                  ram_we;
  logic                  rf_full;
  logic                  wf_full;
  logic                  wf_empty;
  logic                  unused_bits;

  assign unused_bits = ^{rf_full, wf_count,
                         rd_addr[CL_OFFSET-1:0], rd_addr[ADDR_WIDTH-1:CL_OFFSET+MEM_AW],
                         wr_addr[CL_OFFSET-1:0], wr_addr[ADDR_WIDTH-1:CL_OFFSET+MEM_AW]};

  // A read is issued only if its line is guaranteed a FIFO slot when it lands.
  assign rd_room  = rf_count + FCW'(rd_pending);
  assign rd_req   = (rd_state == RD_ACTIVE) && (rd_issue != '0) && (rd_room < FCW'(FIFO_DEPTH));
  assign rd_pop   = rd_en && !empty && (rd_state == RD_ACTIVE);
  assign full     = !((wr_state == WR_ACTIVE) && !wf_full && (wr_push_left != '0));
  assign wr_push  = wr_en && !full;
  assign wr_req   = (wr_state == WR_ACTIVE) && !wf_empty && (wr_left != '0);
  assign rd_grant = !bd_en && rd_req && (!wr_req || !prio);
  assign wr_grant = !bd_en && wr_req && (!rd_req || prio);

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = rd_line;
    ram_wdata = wf_data;
    if (bd_en) begin
      ram_we    = bd_we;
      ram_addr  = bd_addr;
      ram_wdata = bd_wdata;
    end else if (wr_grant) begin
      ram_we    = 1'b1;
      ram_addr  = wr_line;
      ram_wdata = wf_data;
    end else begin
      ram_we    = 1'b0;
      ram_addr  = rd_line;
      ram_wdata = wf_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      rd_q       <= '0;
      bd_rdata   <= '0;
      prio       <= 1'b0;
    end else begin
      rd_pending <= rd_grant;
      if (rd_grant) begin
        rd_q <= mem[ram_addr];
      end
      if (bd_en && !bd_we) begin
        bd_rdata <= mem[ram_addr];
      end
      // Contested slot: the channel that lost gets the next one.
      if (rd_grant && wr_req) begin
        prio <= 1'b1;
      end else if (wr_grant && rd_req) begin
        prio <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_line  <= '0;
      rd_issue <= '0;
      rd_left  <= '0;
      rd_done  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE, RD_DONE: begin
          if (rd_go) begin
            rd_line  <= rd_addr[CL_OFFSET +: MEM_AW];
            rd_issue <= rd_size;
            rd_left  <= rd_size;
            rd_done  <= 1'b0;
            rd_state <= RD_ACTIVE;
          end
        end
        RD_ACTIVE: begin
          if (rd_grant) begin
            rd_line  <= rd_line + MEM_AW'(1);
            rd_issue <= rd_issue - SIZE_WIDTH'(1);
          end
          if (rd_left == '0) begin
            rd_state <= RD_DONE;
            rd_done  <= 1'b1;
          end else if (rd_pop) begin
            rd_left <= rd_left - SIZE_WIDTH'(1);
            if (rd_left == SIZE_WIDTH'(1)) begin
              rd_state <= RD_DONE;
              rd_done  <= 1'b1;
            end
          end
        end
        default: begin
          rd_state <= RD_IDLE;
          rd_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state     <= WR_IDLE;
      wr_line      <= '0;
      wr_push_left <= '0;
      wr_left      <= '0;
      wr_done      <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE, WR_DONE: begin
          if (wr_go) begin
            wr_line      <= wr_addr[CL_OFFSET +: MEM_AW];
            wr_push_left <= wr_size;
            wr_left      <= wr_size;
            wr_done      <= 1'b0;
            wr_state     <= WR_ACTIVE;
          end
        end
        WR_ACTIVE: begin
          if (wr_push) begin
            wr_push_left <= wr_push_left - SIZE_WIDTH'(1);
          end
          if (wr_left == '0) begin
            wr_state <= WR_DONE;
            wr_done  <= 1'b1;
          end else if (wr_grant) begin
            wr_line <= wr_line + MEM_AW'(1);
            wr_left <= wr_left - SIZE_WIDTH'(1);
            if (wr_left == SIZE_WIDTH'(1)) begin
              wr_state <= WR_DONE;
              wr_done  <= 1'b1;
            end
          end
        end
        default: begin
          wr_state <= WR_IDLE;
          wr_done  <= 1'b0;
        end
      endcase
    end
  end

  dma_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pending),
    .wdata (rd_q),
    .pop   (rd_pop),
    .rdata (rd_data),
    .full  (rf_full),
    .empty (empty),
    .count (rf_count)
  );

  dma_resp_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_push),
    .wdata (wr_data),
    .pop   (wr_grant),
    .rdata (wf_data),
    .full  (wf_full),
    .empty (wf_empty),
    .count (wf_count)
  );

endmodule

// File: doc/dma_responder.md
# dma_responder

Memory-backed responder for the cache-line DMA interface: the host end that a DMA user (e.g. the miner AFU) connects to. Serves read transfers by streaming lines from a local RAM through a FWFT read FIFO. Commits write transfers from a write FIFO into the same RAM. Used to run AFU logic without the platform shell, and carries a backdoor port so benches can preload and inspect memory.

## Interface
Parameters:
- DATA_WIDTH, 512: cache-line width in bits.
- ADDR_WIDTH, 64: virtual byte-address width.
- SIZE_WIDTH, 43: transfer-size width, in lines.
- MEM_AW, 10: log2 of RAM depth, in lines.
- FIFO_DEPTH, 8: depth of each channel FIFO, power of 2.

Ports (flat; names match dma_if fields):
- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- rd_addr  in  ADDR_WIDTH: read start byte address, sampled on rd_go.
- rd_size  in  SIZE_WIDTH: lines to read, sampled on rd_go.
- rd_go  in  1: start read transfer.
- rd_en  in  1: pop rd_data.
- rd_data  out  DATA_WIDTH: head of read FIFO, valid when empty=0.
- empty  out  1: read FIFO empty.
- rd_done  out  1: all rd_size lines popped; stays high until the next accepted rd_go.
- wr_addr  in  ADDR_WIDTH: write start byte address, sampled on wr_go.
- wr_size  in  SIZE_WIDTH: lines to write, sampled on wr_go.
- wr_go  in  1: start write transfer.
- wr_en  in  1: push wr_data.
- wr_data  in  DATA_WIDTH: line to write.
- full  out  1: write push not accepted.
- wr_done  out  1: all wr_size lines committed to RAM; stays high until the next accepted wr_go.
- bd_en  in  1: backdoor access.
- bd_we  in  1: backdoor write (read when 0).
- bd_addr  in  MEM_AW: backdoor line index.
- bd_wdata  in  DATA_WIDTH: backdoor write data.
- bd_rdata  out  DATA_WIDTH: backdoor read data, 1-cycle latency.

## Operation
- Line index = byte address bits [6 +: MEM_AW]. Low 6 bits are ignored. Increment wraps modulo 2^MEM_AW.
- Read channel FSM RD_IDLE / RD_ACTIVE / RD_DONE:
  - rd_go is accepted only in RD_IDLE or RD_DONE; it is ignored in RD_ACTIVE.
  - Accept latches the line index, sets issue count = rd_size and pop count = rd_size, clears rd_done, and enters RD_ACTIVE.
  - RD_ACTIVE issues RAM reads while issue count > 0 and FIFO free slots > in-flight reads.
  - Each rd_en with empty=0 pops one line and decrements pop count. rd_en while empty=1 is ignored.
  - Pop count reaching 0 moves the FSM to RD_DONE, with rd_done=1 from the next cycle.
  - rd_size=0: go to RD_DONE on the cycle after the go.
- Write channel FSM WR_IDLE / WR_ACTIVE / WR_DONE:
  - Accept rules for wr_go match rd_go. Accept latches the index and counts, clears wr_done, and enters WR_ACTIVE.
  - full = 1 unless in WR_ACTIVE with FIFO not full and pushes accepted < wr_size.
  - wr_en while full=1 is dropped.
  - The FIFO drains one line per granted RAM slot. WR_DONE is entered after the wr_size-th RAM write.
  - wr_size=0: go to WR_DONE on the next cycle.
- RAM is single-port, one access per cycle. Priority: backdoor > alternating read-issue/write-drain. When both channels request, the grant toggles and the loser is granted next cycle.
- Reset clears FSMs, counters, FIFOs, rd_done and wr_done. RAM contents are not reset. Reset mid-transfer abandons the transfer.

## Timing
- Reset values: rd_data=0, empty=1, rd_done=0, full=1, wr_done=0, bd_rdata=0.
- Read first-line latency without contention: rd_go sampled at edge 0 → RAM read at edge 1 → FIFO write at edge 2 → empty=0 after edge 2.
- Sustained rate 1 line/cycle per channel with no contention; 1 line per 2 cycles each when both channels are busy.
- rd_done rises the cycle after the final pop. wr_done rises the cycle after the final RAM write.
- rd_go and rd_en in the same cycle in RD_DONE: go accepted, rd_en ignored.
- Simultaneous FIFO push and pop when full (read FIFO) or empty (write FIFO) is not possible by construction.

## Structure
- Package dma_responder_pkg holds:
  - CL_OFFSET=6.
  - typedef line_t (DATA_WIDTH bits).
  - typedef count_t (SIZE_WIDTH bits).
  - rd_state_t and wr_state_t enums.
- One sub-module, dma_resp_fifo: parameterized FWFT FIFO with full/empty/count, instantiated once per channel.
- RAM is an inferred single-port array inside dma_responder.

## Test plan
- Backdoor-load lines 0..3 = k, rd_addr=0, rd_size=4, rd_en held high → data 0,1,2,3 in order; empty=0 two cycles after go; rd_done=1 one cycle after 4th pop.
- wr_addr=0x1000, wr_size=3, push A,B,C → wr_done=1; backdoor reads of lines 64,65,66 return A,B,C; a 4th push sees full=1.
- rd_size=0 and wr_size=0 → done=1 next cycle; empty stays 1 and full stays 1.
- rd_addr=(2^MEM_AW−1)<<6, rd_size=2 → returns last line then line 0.
- Concurrent read of 8 lines and write of 8 lines with rd_en stalled for 20 cycles → no loss; read FIFO holds 8; both done flags set; RAM matches.
- rst_n pulled low mid-read → empty=1, rd_done=0 immediately; a new rd_go completes normally.
